led_timer_multi: RTL and testbench
==================================

Name: led_timer_multi

Overview:
Parametrised, multi-channel successor of the single-channel fixed 3 s LED stretcher. Each channel turns a one-cycle start pulse into an LED-on window whose length is loaded at start time. Each channel runs in solid or blink mode, with optional retrigger, abort and an end-of-window done pulse. Sits between the game FSM (bust/win/dealer events) and the board LED pins.

Parameters:
N_CH, 4, number of independent channels
CNT_W, 32, width of duration and phase counters
BLINK_HALF, 25_000_000, half-period of blink mode in clk cycles (0.25 s at 100 MHz); must be >= 1
RETRIGGER, 1, 1 = start on an active channel reloads it; 0 = start on an active channel is ignored

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
start_pulse  in  N_CH  per-channel one-cycle start request
stop_pulse  in  N_CH  per-channel abort request
mode_blink  in  N_CH  per-channel mode, sampled only when a start is accepted: 0 = solid, 1 = blink
dur_cycles  in  CNT_W  window length in clk cycles, shared by all channels, sampled when a start is accepted
led  out  N_CH  LED drive
busy  out  N_CH  channel window active
done_pulse  out  N_CH  one-cycle pulse when a window expires naturally

Behaviour:
- All outputs are registered. Reset drives led, busy and done_pulse to 0, all states to IDLE and all counters to 0. Reset asserted mid-window kills the window with no done_pulse.
- Per-channel states: IDLE, ACTIVE. Channels are fully independent; the same dur_cycles value may start several channels in one cycle.
- Start accepted at edge T when start_pulse=1, stop_pulse=0, dur_cycles!=0, and either state=IDLE or RETRIGGER=1.
  - On acceptance: state=ACTIVE, rem=dur_cycles-1, mode latched, ph=BLINK_HALF-1, blink_bit=1.
  - busy and led go high after edge T.
- dur_cycles=0: start is ignored and the channel state is unchanged.
- ACTIVE, each edge with no accepted start and no stop:
  - rem==0: state becomes IDLE and done_pulse=1 for exactly one cycle.
  - otherwise rem decrements.
  - Result: busy is high for exactly dur_cycles cycles, and done_pulse coincides with the first cycle busy is low.
- Blink mode, each ACTIVE edge:
  - ph==0: blink_bit toggles and ph reloads to BLINK_HALF-1.
  - otherwise ph decrements.
  - led = busy AND blink_bit, so high for BLINK_HALF cycles, low for BLINK_HALF cycles, and so on. The window may end in either phase.
- Solid mode: led = busy.
- stop_pulse=1: state becomes IDLE at the next edge. led and busy drop and no done_pulse is issued. stop beats start in the same cycle. stop on an IDLE channel has no effect.
- Retrigger (RETRIGGER=1), start accepted while ACTIVE, including on the expiry edge: reload exactly as from IDLE, no done_pulse, busy stays high continuously.
- RETRIGGER=0: start while ACTIVE is dropped, including on the expiry edge. The channel expires normally.
- No arithmetic wraps: rem and ph never decrement below 0.

Decomposition:
- Shared package led_timer_pkg: state typedef {IDLE, ACTIVE}; mode constants MODE_SOLID=0, MODE_BLINK=1.
- One sub-module led_timer_ch: a single channel with scalar start, stop and mode, plus the shared dur_cycles and the parameters.
- Top level generates N_CH instances and concatenates their outputs.

Test Plan:
(Bench parameters: N_CH=4, BLINK_HALF=3, RETRIGGER=1 unless noted.)
1. Solid: dur=5, start ch0 at cycle 10 -> led[0]=busy[0]=1 in cycles 11..15; done_pulse[0]=1 in cycle 16 only; channels 1-3 stay 0.
2. Blink: dur=10, mode_blink=1, start ch1 at cycle 0 -> led[1] pattern over cycles 1..10 is 1,1,1,0,0,0,1,1,1,0; done_pulse[1] in cycle 11.
3. Retrigger: dur=5, start ch2 at cycle 0 and again at cycle 3 -> busy[2] high cycles 1..8 unbroken; single done_pulse at cycle 9. Repeat with RETRIGGER=0 -> busy cycles 1..5, done at 6.
4. Abort: dur=8, start ch3 at cycle 0, stop at cycle 4 -> led[3]=0 from cycle 5; no done_pulse. start and stop together on IDLE ch3 -> stays IDLE.
5. Boundaries: dur=0 start -> nothing. dur=1 -> busy for exactly 1 cycle, then done. start on the expiry edge (RETRIGGER=1) -> busy continuous, no done.
6. Reset: rst=1 at cycle 3 of a dur=20 window on all channels -> all outputs 0 next cycle; no done_pulse; new start after rst=0 behaves as test 1.

Source files
------------

// File: rtl/led_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_timer_pkg
// Description : Shared types and constants for the multi-channel LED timer.
// Revision    : 1.0 - initial release
// ============================================================================
package led_timer_pkg;

  // Per-channel window state; explicit 1-bit encoding.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Channel display modes, latched when a start is accepted.
  localparam logic MODE_SOLID = 1'b0;
  localparam logic MODE_BLINK = 1'b1;

endpackage : led_timer_pkg
`default_nettype wire

// File: rtl/led_timer_ch.sv
`default_nettype none
// ============================================================================
// Module      : led_timer_ch
// Description : One LED stretcher channel. Turns a start pulse into a window
//               of dur_cycles clocks, solid or blinking, with abort, optional
//               retrigger and a done pulse on natural expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module led_timer_ch
  import led_timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int BLINK_HALF = 25_000_000,
  parameter int RETRIGGER  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_pulse,
  input  logic             stop_pulse,
  input  logic             mode_blink,
  input  logic [CNT_W-1:0] dur_cycles,
  output logic             led,
  output logic             busy,
  output logic             done_pulse
);

  localparam logic [CNT_W-1:0] c_PH_RELOAD = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_ph;
  logic             r_blink_bit;
  logic             r_mode;
  logic             r_led;
  logic             r_done;

  logic             w_accept;
  logic             w_ph_wrap;
  logic             w_blink_next;

  // A start is taken only without a concurrent stop, with a non-zero length,
  // and (unless retrigger is enabled) only from an idle channel.
  assign w_accept = start_pulse && !stop_pulse && (dur_cycles != '0) &&
                    ((r_state == IDLE) || (RETRIGGER != 0));

  // Blink phase bookkeeping for the current ACTIVE edge.
  assign w_ph_wrap    = (r_ph == '0);
  assign w_blink_next = w_ph_wrap ? !r_blink_bit : r_blink_bit;

  // Channel state machine with registered led/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_ph        <= '0;
      r_blink_bit <= 1'b0;
      r_mode      <= MODE_SOLID;
      r_led       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop_pulse) begin
        // Abort: silent return to idle, no done pulse.
        r_state <= IDLE;
        r_led   <= 1'b0;
      end else if (w_accept) begin
        r_state     <= ACTIVE;
        r_rem       <= dur_cycles - c_ONE;
        r_mode      <= mode_blink;
        r_ph        <= c_PH_RELOAD;
        r_blink_bit <= 1'b1;
        r_led       <= 1'b1;
      end else if (r_state == ACTIVE) begin
        if (r_rem == '0) begin
          r_state <= IDLE;
          r_led   <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_rem       <= r_rem - c_ONE;
          r_ph        <= w_ph_wrap ? c_PH_RELOAD : (r_ph - c_ONE);
          r_blink_bit <= w_blink_next;
          r_led       <= (r_mode == MODE_BLINK) ? w_blink_next : 1'b1;
        end
      end
    end
  end

  assign busy       = (r_state == ACTIVE);
  assign led        = r_led;
  assign done_pulse = r_done;

endmodule : led_timer_ch
`default_nettype wire

// File: rtl/led_timer_multi.sv
`default_nettype none
// ============================================================================
// Module      : led_timer_multi
// Description : N_CH independent LED stretcher channels sharing one duration
//               input; outputs are concatenated per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module led_timer_multi
  import led_timer_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int BLINK_HALF = 25_000_000,
  parameter int RETRIGGER  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  start_pulse,
  input  logic [N_CH-1:0]  stop_pulse,
  input  logic [N_CH-1:0]  mode_blink,
  input  logic [CNT_W-1:0] dur_cycles,
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  done_pulse
);

  // One timer per channel; all share clock, reset and dur_cycles.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_timer_ch #(
      .CNT_W      (CNT_W),
      .BLINK_HALF (BLINK_HALF),
      .RETRIGGER  (RETRIGGER)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .start_pulse (start_pulse[g]),
      .stop_pulse  (stop_pulse[g]),
      .mode_blink  (mode_blink[g]),
      .dur_cycles  (dur_cycles),
      .led         (led[g]),
      .busy        (busy[g]),
      .done_pulse  (done_pulse[g])
    );
  end : g_ch

endmodule : led_timer_multi
`default_nettype wire

// File: tb/tb_led_timer_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_timer_multi
// Description : Self-checking bench for led_timer_multi. Two instances
//               (retrigger on / off) share stimulus and are compared every
//               cycle against a window-length based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_timer_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam int BH    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  start_pulse;
  logic [N_CH-1:0]  stop_pulse;
  logic [N_CH-1:0]  mode_blink;
  logic [CNT_W-1:0] dur_cycles;
  logic [N_CH-1:0]  led_a, busy_a, done_a;
  logic [N_CH-1:0]  led_b, busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, index 0 = retrigger on, 1 = retrigger off.
  // left = busy cycles still to come, age = cycles since window start.
  int   m_left [2][N_CH];
  int   m_age  [2][N_CH];
  logic m_mode [2][N_CH];
  logic m_done [2][N_CH];

  always #5 clk = ~clk;

  led_timer_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .BLINK_HALF(BH), .RETRIGGER(1)) u_dut_a (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .mode_blink(mode_blink), .dur_cycles(dur_cycles),
    .led(led_a), .busy(busy_a), .done_pulse(done_a));

  led_timer_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .BLINK_HALF(BH), .RETRIGGER(0)) u_dut_b (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .mode_blink(mode_blink), .dur_cycles(dur_cycles),
    .led(led_b), .busy(busy_b), .done_pulse(done_b));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N_CH; c++) begin
        m_done[d][c] = 1'b0;
        if (rst) begin
          m_left[d][c] = 0;
          m_age[d][c]  = 0;
        end else if (stop_pulse[c]) begin
          m_left[d][c] = 0;
        end else if (start_pulse[c] && dur_cycles != 0 && (m_left[d][c] == 0 || d == 0)) begin
          m_left[d][c] = int'(dur_cycles);
          m_age[d][c]  = 0;
          m_mode[d][c] = mode_blink[c];
        end else if (m_left[d][c] > 0) begin
          m_left[d][c]--;
          m_age[d][c]++;
          if (m_left[d][c] == 0) m_done[d][c] = 1'b1;
        end
      end
    end
  endtask

  // Advance one clock, update the model, then compare away from the edge.
  task automatic tick();
    logic [N_CH-1:0] e_busy [2];
    logic [N_CH-1:0] e_led  [2];
    logic [N_CH-1:0] e_done [2];
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N_CH; c++) begin
        e_busy[d][c] = (m_left[d][c] > 0);
        e_led[d][c]  = e_busy[d][c] && (!m_mode[d][c] || ((m_age[d][c] / BH) % 2 == 0));
        e_done[d][c] = m_done[d][c];
      end
    end
    check_eq("busy_rt1", 32'(busy_a), 32'(e_busy[0]));
    check_eq("led_rt1",  32'(led_a),  32'(e_led[0]));
    check_eq("done_rt1", 32'(done_a), 32'(e_done[0]));
    check_eq("busy_rt0", 32'(busy_b), 32'(e_busy[1]));
    check_eq("led_rt0",  32'(led_b),  32'(e_led[1]));
    check_eq("done_rt0", 32'(done_b), 32'(e_done[1]));
  endtask

  task automatic idle(input int n);
    start_pulse = '0;
    stop_pulse  = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [N_CH-1:0] st, input logic [N_CH-1:0] sp,
                       input logic [N_CH-1:0] md, input int dur);
    start_pulse = st;
    stop_pulse  = sp;
    mode_blink  = md;
    dur_cycles  = CNT_W'(dur);
    tick();
    start_pulse = '0;
    stop_pulse  = '0;
  endtask

  initial begin
    logic [9:0] pat;
    pat = 10'b0111000111;  // cycle 1 in bit 0 .. cycle 10 in bit 9
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N_CH; c++) begin
        m_left[d][c] = 0; m_age[d][c] = 0; m_mode[d][c] = 1'b0; m_done[d][c] = 1'b0;
      end
    rst = 1'b1; start_pulse = '0; stop_pulse = '0; mode_blink = '0; dur_cycles = '0;
    idle(2);
    check_eq("reset_led",  32'(led_a | led_b),   32'd0);
    check_eq("reset_busy", 32'(busy_a | busy_b), 32'd0);
    rst = 1'b0;

    // Solid window on ch0.
    idle(10);
    pulse(4'b0001, 4'b0000, 4'b0000, 5);
    idle(8);

    // Blink pattern on ch1.
    pulse(4'b0010, 4'b0000, 4'b0010, 10);
    check_eq("blink_c1", 32'(led_a[1]), 32'(pat[0]));
    for (int i = 1; i < 10; i++) begin
      tick();
      check_eq("blink_pat", 32'(led_a[1]), 32'(pat[i]));
    end
    tick();
    check_eq("blink_done", 32'(done_a[1]), 32'd1);
    idle(2);

    // Retrigger at cycle 3 on ch2.
    pulse(4'b0100, 4'b0000, 4'b0000, 5);
    idle(2);
    pulse(4'b0100, 4'b0000, 4'b0000, 5);
    idle(8);

    // Abort on ch3, then start+stop together on idle ch3.
    pulse(4'b1000, 4'b0000, 4'b0000, 8);
    idle(3);
    pulse(4'b0000, 4'b1000, 4'b0000, 8);
    idle(3);
    pulse(4'b1000, 4'b1000, 4'b0000, 8);
    check_eq("start_stop_idle", 32'(busy_a[3]), 32'd0);
    idle(2);

    // Boundaries: zero length, single cycle, start on the expiry edge.
    pulse(4'b0001, 4'b0000, 4'b0000, 0);
    check_eq("dur0", 32'(busy_a[0]), 32'd0);
    pulse(4'b0001, 4'b0000, 4'b0000, 1);
    check_eq("dur1_busy", 32'(busy_a[0]), 32'd1);
    tick();
    check_eq("dur1_done", 32'(done_a[0]), 32'd1);
    idle(1);
    pulse(4'b0010, 4'b0000, 4'b0000, 3);
    idle(2);
    pulse(4'b0010, 4'b0000, 4'b0000, 3);
    check_eq("expiry_retrig_busy", 32'(busy_a[1]), 32'd1);
    check_eq("expiry_retrig_done", 32'(done_a[1]), 32'd0);
    idle(5);

    // Reset in the middle of windows on every channel.
    pulse(4'b1111, 4'b0000, 4'b0101, 20);
    idle(2);
    rst = 1'b1;
    tick();
    check_eq("rst_mid", 32'({led_a, busy_a, done_a}), 32'd0);
    rst = 1'b0;
    idle(2);
    pulse(4'b0001, 4'b0000, 4'b0000, 5);
    idle(8);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        start_pulse[c] = ($urandom_range(0, 99) < 15);
        stop_pulse[c]  = ($urandom_range(0, 99) < 3);
        mode_blink[c]  = 1'($urandom_range(0, 1));
      end
      dur_cycles = CNT_W'($urandom_range(0, 14));
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_led_timer_multi
`default_nettype wire
